// File: rtl/fetch_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_pipe_ctrl
//
// Front-of-pipeline controller for the MIPS core. It applies the hazard unit's
// stall, bubble and flush requests to the PC register and to the IF/ID
// instruction register. It also owns the per-stage valid chain (ID/EX/MEM/WB)
// that downstream stages use to gate RegWrite and MemWrite. It keeps saturating
// stall and flush statistics, and raises a sticky watchdog flag when a single
// stall lasts MAX_STALL consecutive cycles.
//
// Ports
//   Clk              rising-edge clock
//   Reset            synchronous, active-low reset
//   Instr_IF         instruction read combinationally from IMEM at PC
//   NotStall_PC      1 = PC may advance
//   NotStall_IFID    1 = IF/ID may load
//   MuxControl       0 = insert a bubble into ID/EX
//   Flush_ID/EX/MEM  squash the IF/ID, ID/EX or EX/MEM contents
//   Redirect_Valid   branch/jump target available (taken only together with Flush_ID)
//   Redirect_Target  new PC
//   PC               current fetch address
//   Instr_ID         IF/ID instruction
//   PCPlus4_ID       IF/ID PC+4
//   Valid_ID..WB     stage-valid chain
//   Stall_Count      total stall cycles, saturating
//   Flush_Count      total Flush_ID cycles, saturating
//   Stall_Timeout    sticky watchdog flag
//
// Every output is taken straight from a register, so there is no
// combinational path from any input to any output.
// -----------------------------------------------------------------------------
module fetch_pipe_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CNT_W     = 16,
  parameter int          MAX_STALL = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [31:0]      Instr_IF,
  input  logic             NotStall_PC,
  input  logic             NotStall_IFID,
  input  logic             MuxControl,
  input  logic             Flush_ID,
  input  logic             Flush_EX,
  input  logic             Flush_MEM,
  input  logic             Redirect_Valid,
  input  logic [31:0]      Redirect_Target,
  output logic [31:0]      PC,
  output logic [31:0]      Instr_ID,
  output logic [31:0]      PCPlus4_ID,
  output logic             Valid_ID,
  output logic             Valid_EX,
  output logic             Valid_MEM,
  output logic             Valid_WB,
  output logic [CNT_W-1:0] Stall_Count,
  output logic [CNT_W-1:0] Flush_Count,
  output logic             Stall_Timeout
);

  // The consecutive-stall counter only has to reach MAX_STALL, where it
  // saturates, so it is sized for that value alone.
  localparam int              SC_W   = $clog2(MAX_STALL + 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(MAX_STALL);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [31:0]      r_pc;
  logic [31:0]      r_instr_id;
  logic [31:0]      r_pc4_id;
  logic             r_valid_id;
  logic             r_valid_ex;
  logic             r_valid_mem;
  logic             r_valid_wb;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [SC_W-1:0]  r_consec;
  logic             r_timeout;

  logic [31:0]      w_pc_plus4;
  logic             w_stall;
  logic [31:0]      w_pc_next;
  logic [31:0]      w_instr_next;
  logic [31:0]      w_pc4_next;
  logic             w_valid_id_next;
  logic [SC_W-1:0]  w_consec_next;

  // The add wraps modulo 2^32, so 32'hFFFF_FFFC advances to 0.
  assign w_pc_plus4 = r_pc + 32'd4;

  // A flush cycle is never a stall, even with NotStall_PC low.
  assign w_stall = ~NotStall_PC & ~Flush_ID;

  always_comb begin
    w_pc_next       = r_pc;
    w_instr_next    = r_instr_id;
    w_pc4_next      = r_pc4_id;
    w_valid_id_next = r_valid_id;

    // A redirect is only taken when Flush_ID squashes the wrong-path fetch.
    if (Redirect_Valid && Flush_ID) begin
      w_pc_next = Redirect_Target;
    end else if (NotStall_PC) begin
      w_pc_next = w_pc_plus4;
    end

    // A flush beats the stall. It loads a NOP and clears the valid bit.
    if (Flush_ID) begin
      w_instr_next    = 32'd0;
      w_pc4_next      = 32'd0;
      w_valid_id_next = 1'b0;
    end else if (NotStall_IFID) begin
      w_instr_next    = Instr_IF;
      w_pc4_next      = w_pc_plus4;
      w_valid_id_next = 1'b1;
    end
  end

  assign w_consec_next = !w_stall           ? '0       :
                         (r_consec == SC_MAX) ? r_consec :
                                              r_consec + SC_W'(1);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_pc        <= RESET_PC;
      r_instr_id  <= 32'd0;
      r_pc4_id    <= 32'd0;
      r_valid_id  <= 1'b0;
      r_valid_ex  <= 1'b0;
      r_valid_mem <= 1'b0;
      r_valid_wb  <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_consec    <= '0;
      r_timeout   <= 1'b0;
    end else begin
      // IF -> ID boundary
      r_pc       <= w_pc_next;
      r_instr_id <= w_instr_next;
      r_pc4_id   <= w_pc4_next;
      r_valid_id <= w_valid_id_next;

      // ID -> EX boundary. During a jump/jr stall (MuxControl=1) the ID copy
      // advances while ID holds. The next Flush_ID removes the held duplicate.
      r_valid_ex <= (Flush_EX || !MuxControl) ? 1'b0 : r_valid_id;

      // EX -> MEM boundary
      r_valid_mem <= Flush_MEM ? 1'b0 : r_valid_ex;

      // MEM -> WB boundary
      r_valid_wb <= r_valid_mem;

      if (w_stall) begin
        r_stall_cnt <= sat_inc(r_stall_cnt);
      end
      if (Flush_ID) begin
        r_flush_cnt <= sat_inc(r_flush_cnt);
      end
      r_consec <= w_consec_next;

      // The flag is set on the edge that completes the MAX_STALL-th
      // consecutive stall cycle, and it stays set until reset.
      if (w_consec_next == SC_MAX) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign PC            = r_pc;
  assign Instr_ID      = r_instr_id;
  assign PCPlus4_ID    = r_pc4_id;
  assign Valid_ID      = r_valid_id;
  assign Valid_EX      = r_valid_ex;
  assign Valid_MEM     = r_valid_mem;
  assign Valid_WB      = r_valid_wb;
  assign Stall_Count   = r_stall_cnt;
  assign Flush_Count   = r_flush_cnt;
  assign Stall_Timeout = r_timeout;

endmodule

// File: tb/tb_fetch_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_pipe_ctrl
//
// Scoreboard bench for fetch_pipe_ctrl. Each cycle the stimulus process drives
// the inputs, advances a behavioural model of the front end and queues the
// state it expects after the next rising edge. A separate monitor pops one
// entry after each rising edge and compares it with the DUT outputs. A directed
// opening walks the reset, stall, flush/redirect, watchdog, wrap and saturation
// cases, and randomised traffic follows.
// -----------------------------------------------------------------------------
module tb_fetch_pipe_ctrl;

  localparam int          CNT_W     = 4;
  localparam int          MAX_STALL = 8;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          CNT_MAX   = (1 << CNT_W) - 1;

  logic             Clk = 1'b0;
  logic             Reset;
  logic [31:0]      Instr_IF;
  logic             NotStall_PC, NotStall_IFID, MuxControl;
  logic             Flush_ID, Flush_EX, Flush_MEM;
  logic             Redirect_Valid;
  logic [31:0]      Redirect_Target;
  logic [31:0]      PC, Instr_ID, PCPlus4_ID;
  logic             Valid_ID, Valid_EX, Valid_MEM, Valid_WB;
  logic [CNT_W-1:0] Stall_Count, Flush_Count;
  logic             Stall_Timeout;

  always #5 Clk = ~Clk;

  fetch_pipe_ctrl #(
    .RESET_PC (RESET_PC),
    .CNT_W    (CNT_W),
    .MAX_STALL(MAX_STALL)
  ) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .Instr_IF       (Instr_IF),
    .NotStall_PC    (NotStall_PC),
    .NotStall_IFID  (NotStall_IFID),
    .MuxControl     (MuxControl),
    .Flush_ID       (Flush_ID),
    .Flush_EX       (Flush_EX),
    .Flush_MEM      (Flush_MEM),
    .Redirect_Valid (Redirect_Valid),
    .Redirect_Target(Redirect_Target),
    .PC             (PC),
    .Instr_ID       (Instr_ID),
    .PCPlus4_ID     (PCPlus4_ID),
    .Valid_ID       (Valid_ID),
    .Valid_EX       (Valid_EX),
    .Valid_MEM      (Valid_MEM),
    .Valid_WB       (Valid_WB),
    .Stall_Count    (Stall_Count),
    .Flush_Count    (Flush_Count),
    .Stall_Timeout  (Stall_Timeout)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        vid, vex, vmem, vwb;
    int          sc, fc;
    logic        to;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference state. The counters are plain integers clipped at the top value,
  // and the watchdog is "some stall run has reached MAX_STALL since reset".
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_v[4];
  int          m_sc, m_fc, m_run;
  logic        m_to;

  task automatic step(input logic rst_n, input logic nspc, input logic nsifid,
                      input logic mux, input logic fid, input logic fex,
                      input logic fmem, input logic rv, input logic [31:0] rt,
                      input logic [31:0] instr);
    exp_t        e;
    logic        stall;
    logic [31:0] pc_old;
    Reset = rst_n; NotStall_PC = nspc; NotStall_IFID = nsifid; MuxControl = mux;
    Flush_ID = fid; Flush_EX = fex; Flush_MEM = fmem; Redirect_Valid = rv;
    Redirect_Target = rt; Instr_IF = instr;
    if (!rst_n) begin
      m_pc = RESET_PC; m_instr = 0; m_pc4 = 0;
      for (int i = 0; i < 4; i++) m_v[i] = 1'b0;
      m_sc = 0; m_fc = 0; m_run = 0; m_to = 1'b0;
    end else begin
      stall  = !nspc && !fid;
      pc_old = m_pc;
      if (rv && fid)  m_pc = rt;
      else if (nspc)  m_pc = pc_old + 32'd4;
      m_v[3] = m_v[2];
      m_v[2] = fmem ? 1'b0 : m_v[1];
      m_v[1] = (fex || !mux) ? 1'b0 : m_v[0];
      if (fid) begin
        m_instr = 0; m_pc4 = 0; m_v[0] = 1'b0;
      end else if (nsifid) begin
        m_instr = instr; m_pc4 = pc_old + 32'd4; m_v[0] = 1'b1;
      end
      if (stall) m_sc = (m_sc + 1 > CNT_MAX) ? CNT_MAX : m_sc + 1;
      if (fid)   m_fc = (m_fc + 1 > CNT_MAX) ? CNT_MAX : m_fc + 1;
      m_run = stall ? m_run + 1 : 0;
      if (m_run >= MAX_STALL) m_to = 1'b1;
    end
    e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4;
    e.vid = m_v[0]; e.vex = m_v[1]; e.vmem = m_v[2]; e.vwb = m_v[3];
    e.sc = m_sc; e.fc = m_fc; e.to = m_to;
    q.push_back(e);
    @(negedge Clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", nm, act, want, $time);
    end
  endtask

  // Monitor: one queued expectation per rising edge, sampled 1 time unit later.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("PC",            PC,                  e.pc);
        chk("Instr_ID",      Instr_ID,            e.instr);
        chk("PCPlus4_ID",    PCPlus4_ID,          e.pc4);
        chk("Valid_ID",      32'(Valid_ID),       32'(e.vid));
        chk("Valid_EX",      32'(Valid_EX),       32'(e.vex));
        chk("Valid_MEM",     32'(Valid_MEM),      32'(e.vmem));
        chk("Valid_WB",      32'(Valid_WB),       32'(e.vwb));
        chk("Stall_Count",   32'(Stall_Count),    32'(e.sc));
        chk("Flush_Count",   32'(Flush_Count),    32'(e.fc));
        chk("Stall_Timeout", 32'(Stall_Timeout),  32'(e.to));
      end
    end
  end

  initial begin : stimulus
    logic rst_n, nspc, nsifid, mux, fid, fex, fmem, rv;
    int   burst;
    #1;
    // Reset for two cycles, then free-running fetch up to PC = 0x10.
    repeat (2) step(0, 1, 1, 1, 0, 0, 0, 0, 32'h0, $urandom);
    repeat (4) step(1, 1, 1, 1, 0, 0, 0, 0, 32'h0, $urandom);
    // Three-cycle load-use stall with bubbles into EX.
    repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, $urandom);
    // Full flush with redirect while the PC is stalled.
    step(1, 0, 0, 1, 1, 1, 1, 1, 32'h40, $urandom);
    // Eight-cycle jump stall trips the watchdog, then release and re-stall.
    repeat (8) step(1, 0, 0, 1, 0, 0, 0, 0, 32'h0, $urandom);
    step(1, 1, 1, 1, 0, 0, 0, 0, 32'h0, $urandom);
    repeat (2) step(1, 0, 0, 1, 0, 0, 0, 0, 32'h0, $urandom);
    // PC wrap from the top of the address space.
    step(1, 0, 0, 1, 1, 0, 0, 1, 32'hFFFF_FFFC, $urandom);
    step(1, 1, 1, 1, 0, 0, 0, 0, 32'h0, $urandom);
    // Enough flush cycles to saturate Flush_Count, plus two more.
    repeat (CNT_MAX + 3) step(1, 1, 1, 1, 1, 0, 0, 0, 32'h0, $urandom);
    // Reset arriving in the middle of a stall, together with a redirect+flush.
    repeat (2) step(1, 0, 0, 1, 0, 0, 0, 0, 32'h0, $urandom);
    step(0, 0, 0, 1, 1, 0, 0, 1, 32'h80, $urandom);
    step(1, 1, 1, 1, 0, 0, 0, 0, 32'h0, $urandom);

    // Random traffic, with occasional long stall bursts so the watchdog fires.
    burst = 0;
    for (int n = 0; n < 800; n++) begin
      if (burst == 0 && $urandom_range(0, 31) == 0) burst = $urandom_range(4, 12);
      rst_n  = ($urandom_range(0, 149) != 0);
      nspc   = (burst > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
      nsifid = ($urandom_range(0, 7) == 0) ? !nspc : nspc;
      mux    = ($urandom_range(0, 3) != 0);
      fid    = (burst > 0) ? 1'b0 : ($urandom_range(0, 7) == 0);
      fex    = ($urandom_range(0, 7) == 0);
      fmem   = ($urandom_range(0, 7) == 0);
      rv     = ($urandom_range(0, 1) == 0);
      if (burst > 0) burst--;
      step(rst_n, nspc, nsifid, mux, fid, fex, fmem, rv,
           {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, $urandom);
    end

    repeat (3) @(negedge Clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d want=0 entries left", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_pipe_ctrl.md
Name: fetch_pipe_ctrl

Overview:
Consumes the stall, bubble and flush requests from the hazard unit and applies them to the front of the MIPS pipeline. It owns the PC register and the IF/ID instruction register. It also owns the per-stage valid chain (ID/EX/MEM/WB), which downstream stages use to gate RegWrite and MemWrite. It keeps stall and flush statistics and raises a sticky watchdog flag when a stall lasts too long.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_W, 16, width of the Stall_Count and Flush_Count statistics counters
MAX_STALL, 8, consecutive stall cycles that set Stall_Timeout

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  synchronous, active-low reset (sampled on rising Clk)
Instr_IF  input  32  instruction read combinationally from IMEM at PC
NotStall_PC  input  1  1 = PC may advance
NotStall_IFID  input  1  1 = IF/ID may load
MuxControl  input  1  0 = insert bubble into ID/EX
Flush_ID  input  1  squash IF/ID contents
Flush_EX  input  1  squash ID/EX contents
Flush_MEM  input  1  squash EX/MEM contents
Redirect_Valid  input  1  branch/jump target available
Redirect_Target  input  32  new PC
PC  output  32  current fetch address
Instr_ID  output  32  IF/ID instruction
PCPlus4_ID  output  32  IF/ID PC+4
Valid_ID, Valid_EX, Valid_MEM, Valid_WB  output  1 each  stage-valid chain
Stall_Count  output  CNT_W  total stall cycles, saturating
Flush_Count  output  CNT_W  total Flush_ID cycles, saturating
Stall_Timeout  output  1  sticky watchdog flag

Behaviour:
- Reset (Reset==0 at a rising Clk) sets:
  - PC = RESET_PC.
  - Instr_ID = 0, PCPlus4_ID = 0.
  - All Valid_* = 0.
  - Counters = 0, Stall_Timeout = 0, internal consecutive-stall counter = 0.
  - Reset overrides every other input in the same cycle, including mid-stall and mid-flush.
- PC next-state, in priority order:
  - Redirect_Valid & Flush_ID -> Redirect_Target.
  - Otherwise NotStall_PC -> PC+4. The add wraps modulo 2^32, so 32'hFFFF_FFFC goes to 0.
  - Otherwise hold.
  - Redirect_Valid without Flush_ID is ignored.
- IF/ID next-state, in priority order:
  - Flush_ID -> Instr_ID = 0 (NOP), Valid_ID = 0, PCPlus4_ID = 0.
  - Otherwise NotStall_IFID -> Instr_ID = Instr_IF, PCPlus4_ID = PC+4, Valid_ID = 1.
  - Otherwise hold all three.
- Valid chain, one register per stage, single-cycle latency per stage:
  - Valid_EX <= (Flush_EX | ~MuxControl) ? 0 : Valid_ID.
  - Valid_MEM <= Flush_MEM ? 0 : Valid_EX.
  - Valid_WB <= Valid_MEM.
  - Jump/jr stall (NotStall=0, MuxControl=1): the ID copy advances into EX while the held ID copy stays. The following Flush_ID cycle removes the held duplicate. The block does not suppress it itself.
- Stall cycle definition: NotStall_PC==0 & Flush_ID==0.
  - Stall_Count increments on each stall cycle and saturates at all-ones.
  - Consecutive counter increments on stall cycles and clears to 0 otherwise.
  - When the consecutive counter reaches MAX_STALL, Stall_Timeout <= 1 and stays 1 until reset.
  - The consecutive counter saturates at MAX_STALL.
- Flush_Count increments on each cycle with Flush_ID==1 and saturates.
- Simultaneous events:
  - Flush beats stall for both PC and IF/ID.
  - Flush_EX and ~MuxControl together still yield Valid_EX = 0.
  - Flush cycles never count as stalls.
- All outputs are registered; there is no combinational input-to-output path.

Test Plan:
1. Reset=0 for 2 cycles, then release with NotStall=1, MuxControl=1, no flush. Required: PC = 0, 4, 8 on successive cycles; Valid_ID rises 1 cycle after release; Valid_WB rises 3 cycles after Valid_ID.
2. With PC=0x10, drop NotStall_PC and NotStall_IFID for 3 cycles with MuxControl=0. Required: PC holds 0x10; Instr_ID held; Valid_EX = 0 for 3 cycles; Stall_Count = 3; Stall_Timeout = 0.
3. Assert Flush_ID, Flush_EX, Flush_MEM and Redirect_Valid with Redirect_Target = 0x40 while NotStall_PC=0. Required: next PC = 0x40; Instr_ID = 0; Valid_ID, Valid_EX and Valid_MEM = 0; Flush_Count +1; Stall_Count unchanged.
4. Hold the stall for 8 cycles, release it, then stall again for 2 cycles. Required: Stall_Timeout = 1 after the 8th stall cycle and remains 1; the consecutive counter restarts from 0.
5. Start at PC = 0xFFFF_FFFC with NotStall_PC=1. Required: PC = 0 next cycle. Then force Flush_Count to CNT_W all-ones by driving 2^CNT_W flush cycles (or use CNT_W=4) and assert Flush_ID again. Required: count stays at all-ones.
6. Assert Reset=0 during a 3-cycle stall with Redirect_Valid & Flush_ID. Required: PC = RESET_PC, all valids and counters = 0, Stall_Timeout = 0 on the next edge.
